audio_i2s_rx: RTL and testbench
===============================

// Module: audio_i2s_rx
// PURPOSE
//  Deserialises the codec ADC I2S stream (BCLK/ADCLRCK/ADCDAT) into signed parallel stereo samples.
//  Emits one o_valid strobe per stereo frame, together with a mono sample.
//  Sits directly upstream of the effect chain: o_data/o_valid drive the gate stage's i_data/i_valid.
//  Codec pins are asynchronous to i_clk; all decoding is done in the i_clk domain via synchronised edge detection.
// PARAMETERS
//  DATA_W     16  bits captured per channel, MSB first; extra slot bits are ignored
//  SYNC_STAGES 2  flip-flop synchroniser depth on i_bclk, i_lrck, i_adcdat (legal range 2..4)
//  MONO_MODE   0  o_data source: 0 = left, 1 = right, 2 = (L+R)>>>1
// PORTS
//  i_clk        in   1       system clock; must be at least 4x BCLK
//  i_rst        in   1       asynchronous reset, active-high
//  i_bclk       in   1       codec bit clock (asynchronous)
//  i_lrck       in   1       codec ADC LR clock; 0 = left slot, 1 = right slot
//  i_adcdat     in   1       codec serial data
//  o_data_l     out  DATA_W  signed left sample of the last complete frame
//  o_data_r     out  DATA_W  signed right sample of the last complete frame
//  o_data       out  DATA_W  signed mono sample per MONO_MODE
//  o_valid      out  1       one-cycle strobe: new frame present on o_data*
//  o_locked     out  1       high once the first complete frame has been received
//  o_frame_err  out  1       one-cycle strobe: a slot ended before DATA_W bits were captured
// BEHAVIOUR
//  Reset: all outputs 0; FSM enters ALIGN; shift register, bit counter and synchronisers cleared.
//  Synchroniser: each pin passes through SYNC_STAGES flops. bclk_rise/lrck_edge are 1-cycle pulses
//   taken from the last synchroniser stage and the stage one register after it.
//  FSM:
//   ALIGN: wait for an lrck falling edge (start of the left slot) -> SKIP. lrck rising edges are ignored.
//   SKIP:  consume one bclk_rise (the I2S one-bit delay) -> SHIFT, with bit_cnt=0.
//   SHIFT: on each bclk_rise, shift adcdat into the LSB and increment bit_cnt.
//          When bit_cnt reaches DATA_W, latch the word into the slot holding register -> WAIT.
//   WAIT:  ignore bclk until lrck_edge -> SKIP.
//   lrck_edge while in SKIP/SHIFT (short slot): pulse o_frame_err, discard the partial word,
//    drop o_locked, -> ALIGN. Outputs o_data* keep their previous values.
//  If lrck_edge and bclk_rise occur in the same cycle, lrck_edge is processed first;
//   that bclk_rise counts as the SKIP bit of the new slot.
//  Frame completion: the right word is latched at cycle N, where N is the cycle of the DATA_W-th
//   right-slot bclk_rise.
//   At N+1: o_data_l/o_data_r/o_data update, o_valid=1 for exactly one cycle, o_locked=1.
//   The left word is held internally until then, so L and R always come from the same frame.
//  MONO_MODE 2: sign-extend both channels to DATA_W+1 bits, add, arithmetic shift right by 1.
//   No overflow is possible (0x7FFF+0x7FFF -> 0x7FFF; 0x8000+0x8000 -> 0x8000).
//  Outputs hold between strobes; o_valid is never asserted twice within one frame.
//  A right slot whose left slot was lost (lock acquired mid-frame) produces no strobe.
//   The first o_valid needs a full L+R frame after ALIGN exits.
//  Reset mid-frame: immediate return to the reset state; the partial frame is never emitted.
// TESTING
//  1. Reset, then send frame L=0x1234, R=0xFEDC (BCLK = i_clk/8) -> one o_valid;
//     o_data_l=0x1234, o_data_r=0xFEDC, o_data=0x1234, o_locked=1.
//  2. MONO_MODE=2: L=0x7FFF, R=0x7FFF -> o_data=0x7FFF.
//     L=0x8000, R=0x8000 -> 0x8000. L=0x0003, R=0xFFFF -> 0x0001.
//  3. 32-bit slots, 16 MSBs 0xA5A5/0x5A5A, trailing bits 0xFFFF -> outputs 0xA5A5/0x5A5A;
//     exactly one o_valid per frame across 10 frames.
//  4. Start the stream mid right slot -> no o_valid until the next full L+R frame; first strobe carries that frame.
//  5. Toggle lrck after 8 bits of a left slot -> o_frame_err pulse, o_locked=0, no o_valid, o_data* unchanged;
//     the next clean frame re-locks.
//  6. Assert i_rst during bit 10 of a right slot -> all outputs 0 the same cycle.
//     After release, the first o_valid comes after the next complete frame.

Source files
------------

// File: rtl/audio_i2s_rx_if.sv
// Parallel sample bus leaving the I2S receiver: stereo words, mono mix and status strobes.
interface audio_i2s_rx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] data_l;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              locked;
  logic              frame_err;

  modport master (output data_l, data_r, data, valid, locked, frame_err);
  modport slave  (input  data_l, data_r, data, valid, locked, frame_err);
endinterface

// File: rtl/audio_i2s_rx.sv
// I2S ADC receiver: synchronises the codec pins into i_clk, deserialises MSB-first
// left/right words and emits one stereo frame plus a mono sample per valid strobe.
module audio_i2s_rx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MONO_MODE   = 0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_bclk,
  input  logic           i_lrck,
  input  logic           i_adcdat,
  audio_i2s_rx_if.master rx_bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_SKIP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [SYNC_STAGES-1:0] bclk_sync_r, lrck_sync_r, dat_sync_r;
  logic                   bclk_d_r, lrck_d_r;
  logic                   bclk_rise_s, lrck_edge_s, lrck_fall_s, lrck_s, dat_s;
  logic                   slot_start_s, shift_en_s, word_done_s, err_s;
  logic [DATA_W-2:0]      shift_r;
  logic [DATA_W-1:0]      word_s, left_hold_r, mono_s;
  logic signed [DATA_W:0] sum_s;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic                   slot_r, have_left_r;
  logic [DATA_W-1:0]      left_out_r, right_out_r, mono_out_r;
  logic                   valid_r, locked_r, frame_err_r;

  assign lrck_s      = lrck_sync_r[SYNC_STAGES-1];
  assign dat_s       = dat_sync_r[SYNC_STAGES-1];
  assign bclk_rise_s = bclk_sync_r[SYNC_STAGES-1] & ~bclk_d_r;
  assign lrck_edge_s = lrck_s ^ lrck_d_r;
  assign lrck_fall_s = ~lrck_s & lrck_d_r;
  assign word_s      = {shift_r, dat_s};

  // Pin synchronisers plus one extra stage for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bclk_sync_r <= '0;
      lrck_sync_r <= '0;
      dat_sync_r  <= '0;
      bclk_d_r    <= 1'b0;
      lrck_d_r    <= 1'b0;
    end else begin
      bclk_sync_r <= {bclk_sync_r[SYNC_STAGES-2:0], i_bclk};
      lrck_sync_r <= {lrck_sync_r[SYNC_STAGES-2:0], i_lrck};
      dat_sync_r  <= {dat_sync_r[SYNC_STAGES-2:0], i_adcdat};
      bclk_d_r    <= bclk_sync_r[SYNC_STAGES-1];
      lrck_d_r    <= lrck_s;
    end
  end

  // Slot state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_ALIGN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; an lrck edge wins over a coincident bclk rise, which then serves as the skip bit.
  always_comb begin
    state_nxt_s  = state_r;
    slot_start_s = 1'b0;
    shift_en_s   = 1'b0;
    word_done_s  = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      ST_ALIGN: begin
        if (lrck_fall_s) begin
          slot_start_s = 1'b1;
          state_nxt_s  = bclk_rise_s ? ST_SHIFT : ST_SKIP;
        end else begin
          state_nxt_s = ST_ALIGN;
        end
      end
      ST_SKIP: begin
        if (lrck_edge_s) begin
          err_s       = 1'b1;
          state_nxt_s = ST_ALIGN;
        end else if (bclk_rise_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_SKIP;
        end
      end
      ST_SHIFT: begin
        if (lrck_edge_s) begin
          err_s       = 1'b1;
          state_nxt_s = ST_ALIGN;
        end else if (bclk_rise_s) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == LAST_BIT) begin
            word_done_s = 1'b1;
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_WAIT: begin
        if (lrck_edge_s) begin
          slot_start_s = 1'b1;
          state_nxt_s  = bclk_rise_s ? ST_SHIFT : ST_SKIP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_ALIGN;
    endcase
  end

  // Mono source selection; the mix is one bit wider so the sum cannot overflow.
  always_comb begin
    sum_s = $signed({left_hold_r[DATA_W-1], left_hold_r}) + $signed({word_s[DATA_W-1], word_s});
    case (MONO_MODE)
      32'd0:   mono_s = left_hold_r;
      32'd1:   mono_s = word_s;
      32'd2:   mono_s = DATA_W'(sum_s >>> 1);
      default: mono_s = left_hold_r;
    endcase
  end

  // Shift register, left-word hold and registered frame outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shift_r     <= '0;
      bit_cnt_r   <= '0;
      slot_r      <= 1'b0;
      left_hold_r <= '0;
      have_left_r <= 1'b0;
      left_out_r  <= '0;
      right_out_r <= '0;
      mono_out_r  <= '0;
      valid_r     <= 1'b0;
      locked_r    <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      if (slot_start_s) begin
        bit_cnt_r <= '0;
        slot_r    <= lrck_s;
      end else if (shift_en_s) begin
        shift_r   <= word_s[DATA_W-2:0];
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end
      if (word_done_s) begin
        if (!slot_r) begin
          left_hold_r <= word_s;
          have_left_r <= 1'b1;
        end else if (have_left_r) begin
          left_out_r  <= left_hold_r;
          right_out_r <= word_s;
          mono_out_r  <= mono_s;
          valid_r     <= 1'b1;
          locked_r    <= 1'b1;
          have_left_r <= 1'b0;
        end
      end
      if (err_s) begin
        shift_r     <= '0;
        have_left_r <= 1'b0;
        locked_r    <= 1'b0;
        frame_err_r <= 1'b1;
      end
    end
  end

  assign rx_bus.data_l    = left_out_r;
  assign rx_bus.data_r    = right_out_r;
  assign rx_bus.data      = mono_out_r;
  assign rx_bus.valid     = valid_r;
  assign rx_bus.locked    = locked_r;
  assign rx_bus.frame_err = frame_err_r;
endmodule

// File: tb/tb_audio_i2s_rx.sv
// Randomised bench for audio_i2s_rx: drives I2S slots and checks against a slot-level model.
module tb_audio_i2s_rx;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst, bclk, lrck, adcdat;
  always #5 clk = ~clk;

  audio_i2s_rx_if #(.DATA_W(DATA_W)) bus0 ();
  audio_i2s_rx_if #(.DATA_W(DATA_W)) bus2 ();

  audio_i2s_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2), .MONO_MODE(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_bclk(bclk), .i_lrck(lrck), .i_adcdat(adcdat), .rx_bus(bus0)
  );
  audio_i2s_rx #(.DATA_W(DATA_W), .SYNC_STAGES(3), .MONO_MODE(2)) dut_mix (
    .i_clk(clk), .i_rst(rst), .i_bclk(bclk), .i_lrck(lrck), .i_adcdat(adcdat), .rx_bus(bus2)
  );

  int check_cnt = 0;
  int error_cnt = 0;
  int valid0_cnt = 0, valid2_cnt = 0, ferr0_cnt = 0, ferr2_cnt = 0;
  logic [31:0] exp0_q[$];
  logic [31:0] exp2_q[$];
  logic [31:0] f0, f2;

  // Slot-level model state
  bit          m_synced, m_have_left, m_short, m_locked, m_prev_lrck;
  logic [15:0] m_left, m_out_l, m_out_r;
  int          m_frames = 0, m_errs = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mix(input logic [31:0] f);
    int l, r;
    l = $signed(f[31:16]);
    r = $signed(f[15:0]);
    return 16'((l + r) >>> 1);
  endfunction

  function automatic void model_reset();
    m_frames    = m_frames - exp0_q.size();
    exp0_q.delete();
    exp2_q.delete();
    m_synced    = 1'b0;
    m_have_left = 1'b0;
    m_short     = 1'b0;
    m_locked    = 1'b0;
    m_out_l     = 16'h0000;
    m_out_r     = 16'h0000;
    m_prev_lrck = lrck;
  endfunction

  // Decides, from the whole slot description, what the receiver must report.
  function automatic void model_slot(input bit lr, input logic [15:0] word, input int nper);
    bit new_slot = (lr != m_prev_lrck);
    bit full     = (nper >= DATA_W + 1);
    m_prev_lrck = lr;
    if (!new_slot) return;
    if (m_synced && m_short) begin
      m_errs++;
      m_synced    = 1'b0;
      m_have_left = 1'b0;
      m_locked    = 1'b0;
      m_short     = 1'b0;
      return;
    end
    if (!m_synced) begin
      if (lr) return;
      m_synced = 1'b1;
    end
    m_short = !full;
    if (!full) return;
    if (!lr) begin
      m_left      = word;
      m_have_left = 1'b1;
    end else if (m_have_left) begin
      exp0_q.push_back({m_left, word});
      exp2_q.push_back({m_left, word});
      m_frames++;
      m_have_left = 1'b0;
      m_locked    = 1'b1;
      m_out_l     = m_left;
      m_out_r     = word;
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_l0"}, 32'(bus0.data_l), 32'(m_out_l));
    check_eq({tag, "_r0"}, 32'(bus0.data_r), 32'(m_out_r));
    check_eq({tag, "_m0"}, 32'(bus0.data), 32'(m_out_l));
    check_eq({tag, "_m2"}, 32'(bus2.data), 32'(mix({m_out_l, m_out_r})));
    check_eq({tag, "_valid"}, 32'(bus0.valid | bus2.valid), 32'd0);
    check_eq({tag, "_locked"}, 32'(bus0.locked | bus2.locked), 32'(m_locked));
    check_eq({tag, "_ferr"}, 32'(bus0.frame_err | bus2.frame_err), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_mid_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_slot(input bit lr, input logic [15:0] word, input int nper,
                           input bit trail_ones, input int rst_at);
    model_slot(lr, word, nper);
    for (int p = 0; p < nper; p++) begin
      if (p == rst_at) do_mid_reset();
      lrck = lr;
      if (p == 0) adcdat = 1'($urandom);
      else if (p <= DATA_W) adcdat = word[DATA_W - p];
      else adcdat = trail_ones ? 1'b1 : 1'($urandom);
      bclk = 1'b0;
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nl, input int nr,
                            input bit trail_ones);
    send_slot(1'b0, l, nl, trail_ones, -1);
    send_slot(1'b1, r, nr, trail_ones, -1);
  endtask

  task automatic check_state(input string ph);
    repeat (16) @(negedge clk);
    check_eq({ph, "_locked0"}, 32'(bus0.locked), 32'(m_locked));
    check_eq({ph, "_locked2"}, 32'(bus2.locked), 32'(m_locked));
    check_eq({ph, "_data_l"}, 32'(bus0.data_l), 32'(m_out_l));
    check_eq({ph, "_data_r"}, 32'(bus0.data_r), 32'(m_out_r));
    check_eq({ph, "_data0"}, 32'(bus0.data), 32'(m_out_l));
    check_eq({ph, "_data2"}, 32'(bus2.data), 32'(mix({m_out_l, m_out_r})));
    check_eq({ph, "_valid_cnt0"}, valid0_cnt, m_frames);
    check_eq({ph, "_valid_cnt2"}, valid2_cnt, m_frames);
    check_eq({ph, "_ferr_cnt0"}, ferr0_cnt, m_errs);
    check_eq({ph, "_ferr_cnt2"}, ferr2_cnt, m_errs);
    check_eq({ph, "_pending"}, exp0_q.size() + exp2_q.size(), 32'd0);
  endtask

  // Frame monitor: every strobe must match the oldest frame the model expects.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.valid) begin
        valid0_cnt++;
        check_eq("frame_expected0", 32'(exp0_q.size() != 0), 32'd1);
        if (exp0_q.size() != 0) begin
          f0 = exp0_q.pop_front();
          check_eq("strobe_l0", 32'(bus0.data_l), 32'(f0[31:16]));
          check_eq("strobe_r0", 32'(bus0.data_r), 32'(f0[15:0]));
          check_eq("strobe_mono0", 32'(bus0.data), 32'(f0[31:16]));
        end
      end
      if (bus2.valid) begin
        valid2_cnt++;
        check_eq("frame_expected2", 32'(exp2_q.size() != 0), 32'd1);
        if (exp2_q.size() != 0) begin
          f2 = exp2_q.pop_front();
          check_eq("strobe_l2", 32'(bus2.data_l), 32'(f2[31:16]));
          check_eq("strobe_r2", 32'(bus2.data_r), 32'(f2[15:0]));
          check_eq("strobe_mix2", 32'(bus2.data), 32'(mix(f2)));
        end
      end
      if (bus0.frame_err) ferr0_cnt++;
      if (bus2.frame_err) ferr2_cnt++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    bclk   = 1'b1;
    lrck   = 1'b1;
    adcdat = 1'b0;
    do_reset();
    check_reset_outputs("reset");

    send_frame(16'h1234, 16'hFEDC, 32, 32, 1'b0);
    check_state("basic");

    send_frame(16'h7FFF, 16'h7FFF, int'($urandom_range(40, 17)), int'($urandom_range(40, 17)), 1'b0);
    send_frame(16'h8000, 16'h8000, int'($urandom_range(40, 17)), int'($urandom_range(40, 17)), 1'b0);
    send_frame(16'h0003, 16'hFFFF, 17, 17, 1'b0);
    check_state("mix");

    for (int i = 0; i < 10; i++) send_frame(16'hA5A5, 16'h5A5A, 32, 32, 1'b1);
    check_state("slot32");

    do_reset();
    send_slot(1'b1, 16'($urandom), 10, 1'b0, -1);
    send_frame(16'($urandom), 16'($urandom), 24, 24, 1'b0);
    check_state("midstart");

    send_slot(1'b0, 16'h0F0F, 9, 1'b0, -1);
    send_slot(1'b1, 16'($urandom), 32, 1'b0, -1);
    check_state("short");
    send_frame(16'($urandom), 16'($urandom), 32, 32, 1'b0);
    check_state("relock");

    send_slot(1'b0, 16'($urandom), 32, 1'b0, -1);
    send_slot(1'b1, 16'($urandom), 32, 1'b0, 10);
    check_state("rst_mid");
    send_frame(16'($urandom), 16'($urandom), 32, 32, 1'b0);
    check_state("post_rst");

    for (int i = 0; i < 15; i++) begin
      send_frame(16'($urandom), 16'($urandom), int'($urandom_range(40, 17)),
                 int'($urandom_range(40, 17)), 1'b0);
    end
    check_state("random");

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end
endmodule
